// File: rtl/ifu_pkg.sv
// Shared types and constants for the npc instruction-fetch unit.
package ifu_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam int          ILEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam int          INSTR_BYTES  = 4;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response channel and decode-side output channel.
interface ifu_fetch_if #(
    parameter int XLEN = 32,
    parameter int ILEN = 32
) ();

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_instr;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready
    );

endinterface

// File: rtl/ifu_fetch_chk.sv
// Simulation-only protocol checks for ifu_fetch.
module ifu_fetch_chk (
    input logic clk,
    input logic reset,
    input logic rsp_unexpected
);

    a_rsp_without_request: assert property (@(posedge clk) disable iff (reset) !rsp_unexpected)
        else $error("ifu_fetch: imem response with no outstanding request");

endmodule

// File: rtl/ifu_fifo.sv
// Generic synchronous FIFO with flush; push and pop may coincide even when full.
module ifu_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return PW'(0);
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == CW'(0));
    assign count     = count_q;
    assign pop_data  = mem_q[rd_ptr_q];
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);

    // Pointer and occupancy bookkeeping; flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= PW'(0);
            wr_ptr_q <= PW'(0);
            count_q  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: sequential PC generation, in-order imem requests, fetch queue, redirect.
// Optional FETCH_TRACE_EN prints delivered instructions and redirects.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int              XLEN            = XLEN_DEF,
    parameter int              ILEN            = ILEN_DEF,
    parameter int              DEPTH           = 4,
    parameter int              MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    ifu_fetch_if.master     bus
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = $clog2(DEPTH + 1);
    localparam int EW = XLEN + ILEN;

    logic [XLEN-1:0] fetch_pc_q,    fetch_pc_d;
    logic [OW-1:0]   outstanding_q, outstanding_d;
    logic [OW-1:0]   drop_cnt_q,    drop_cnt_d;

    logic            req_valid_s, req_fire_s;
    logic            rsp_ok_s, bypass_s, keep_s, out_fire_s;
    logic [XLEN-1:0] inflight_pc_s, rsp_pc_s;
    logic [OW-1:0]   inflight_count_s;
    logic            inflight_full_s, inflight_empty_s;
    logic [EW-1:0]   q_head_s;
    logic [QW-1:0]   q_count_s;
    logic            q_full_s, q_empty_s;
    logic            unused_s;

    // Space for every response is reserved at issue, so the queue can never overflow.
    assign req_valid_s = !reset && !redirect_valid
                       && ((32'(outstanding_q) + 32'(q_count_s)) < 32'(DEPTH))
                       && (32'(outstanding_q) < 32'(MAX_OUTSTANDING));
    assign req_fire_s  = req_valid_s && bus.imem_req_ready;

    // A zero-latency response to this cycle's request bypasses the in-flight PC FIFO.
    assign bypass_s    = bus.imem_rsp_valid && req_fire_s && (outstanding_q == OW'(0));
    assign rsp_ok_s    = bus.imem_rsp_valid && ((outstanding_q != OW'(0)) || req_fire_s);
    assign keep_s      = rsp_ok_s && (drop_cnt_q == OW'(0)) && !redirect_valid;
    assign rsp_pc_s    = bypass_s ? fetch_pc_q : inflight_pc_s;
    assign out_fire_s  = bus.out_valid && bus.out_ready;

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.out_valid      = !reset && !q_empty_s;
    assign bus.out_pc         = bus.out_valid ? q_head_s[EW-1:ILEN] : XLEN'(0);
    assign bus.out_instr      = bus.out_valid ? q_head_s[ILEN-1:0]  : ILEN'(0);

    assign unused_s = &{1'b0, q_full_s, inflight_full_s, inflight_empty_s,
                        inflight_count_s, redirect_pc[1:0]};

    ifu_fifo #(.WIDTH(XLEN), .DEPTH(MAX_OUTSTANDING)) u_inflight (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (req_fire_s && !bypass_s),
        .push_data (fetch_pc_q),
        .pop       (rsp_ok_s && (drop_cnt_q == OW'(0)) && !bypass_s),
        .pop_data  (inflight_pc_s),
        .count     (inflight_count_s),
        .full      (inflight_full_s),
        .empty     (inflight_empty_s)
    );

    ifu_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (keep_s),
        .push_data ({rsp_pc_s, bus.imem_rsp_data}),
        .pop       (out_fire_s),
        .pop_data  (q_head_s),
        .count     (q_count_s),
        .full      (q_full_s),
        .empty     (q_empty_s)
    );

    // Next-state for PC, outstanding count and the stale-response drop counter.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        case ({req_fire_s, rsp_ok_s})
            2'b10:   outstanding_d = outstanding_q + OW'(1);
            2'b01:   outstanding_d = outstanding_q - OW'(1);
            default: outstanding_d = outstanding_q;
        endcase
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            drop_cnt_d = outstanding_q - OW'(rsp_ok_s);
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (rsp_ok_s && (drop_cnt_q != OW'(0))) begin
                drop_cnt_d = drop_cnt_q - OW'(1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= OW'(0);
            drop_cnt_q    <= OW'(0);
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

`ifdef FETCH_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && out_fire_s) begin
            $display("PC=0x%08x | instr=0x%08x", bus.out_pc, bus.out_instr);
        end
        if (!reset && redirect_valid) begin
            $display("REDIRECT -> 0x%08x", {redirect_pc[XLEN-1:2], 2'b00});
        end
    end
`else
`endif

`ifndef SYNTHESIS
    ifu_fetch_chk u_chk (
        .clk            (clk),
        .reset          (reset),
        .rsp_unexpected (bus.imem_rsp_valid && !rsp_ok_s)
    );
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch with an in-order memory model.
module tb_ifu_fetch;
    import ifu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    ifu_fetch_if #(.XLEN(32), .ILEN(32)) bus ();

    ifu_fetch #(
        .XLEN(32), .ILEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h8000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    int           checks = 0;
    int           errors = 0;
    bit           rsp_en;
    logic [31:0]  pend[$];
    logic [31:0]  issued[$];
    fetch_entry_t obs[$];

    typedef struct {
        logic        rr;
        logic        orr;
        logic        exp_rv;
        logic [31:0] exp_addr;
        logic        exp_ov;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t vt[9];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08x expected 0x%08x", name, act, exp);
        end
    endtask

    // One clock: present memory response, sample handshakes, advance, update model.
    task automatic tick();
        logic         rf, rs, of_, rst;
        logic [31:0]  ra;
        fetch_entry_t e;
        #1;
        bus.imem_rsp_valid = rsp_en && !reset && (pend.size() > 0);
        bus.imem_rsp_data  = (pend.size() > 0) ? instr_of(pend[0]) : 32'h0;
        #1;
        rf      = bus.imem_req_valid && bus.imem_req_ready;
        ra      = bus.imem_req_addr;
        rs      = bus.imem_rsp_valid;
        of_     = bus.out_valid && bus.out_ready;
        e.pc    = bus.out_pc;
        e.instr = bus.out_instr;
        rst     = reset;
        @(posedge clk);
        #1;
        if (rst) begin
            pend.delete();
        end else begin
            if (rs) void'(pend.pop_front());
            if (rf) begin
                pend.push_back(ra);
                issued.push_back(ra);
            end
        end
        if (of_) obs.push_back(e);
        bus.imem_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        rsp_en         = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        obs.delete();
        issued.delete();
    endtask

    initial begin
        logic        prev_stall;
        logic [31:0] prev_addr;
        bit          pat[4];

        reset              = 1'b1;
        redirect_valid     = 1'b0;
        redirect_pc        = 32'h0;
        rsp_en             = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        #1;
        chk("req_valid_in_reset", {31'h0, bus.imem_req_valid}, 32'h0);

        // Streaming from reset, then a one-cycle request stall and a one-cycle decode stall.
        vt[0] = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
        vt[2] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000};
        vt[3] = '{1'b1, 1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0004};
        vt[4] = '{1'b1, 1'b1, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008};
        vt[5] = '{1'b0, 1'b1, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_000C};
        vt[6] = '{1'b1, 1'b0, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_0010};
        vt[7] = '{1'b1, 1'b1, 1'b1, 32'h8000_0018, 1'b1, 32'h8000_0010};
        vt[8] = '{1'b1, 1'b1, 1'b1, 32'h8000_001C, 1'b1, 32'h8000_0014};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            bus.imem_req_ready = vt[i].rr;
            bus.out_ready      = vt[i].orr;
            #1;
            chk($sformatf("vec%0d_req_valid", i), {31'h0, bus.imem_req_valid}, {31'h0, vt[i].exp_rv});
            chk($sformatf("vec%0d_req_addr", i), bus.imem_req_addr, vt[i].exp_addr);
            chk($sformatf("vec%0d_out_valid", i), {31'h0, bus.out_valid}, {31'h0, vt[i].exp_ov});
            chk($sformatf("vec%0d_out_pc", i), bus.out_pc, vt[i].exp_pc);
            chk($sformatf("vec%0d_out_instr", i), bus.out_instr,
                vt[i].exp_ov ? instr_of(vt[i].exp_pc) : 32'h0);
            tick();
        end

        // Decode stalled for 20 cycles: queue fills to DEPTH, requests stop, head holds.
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b0;
        repeat (20) tick();
        #1;
        chk("stall_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        chk("stall_out_valid", {31'h0, bus.out_valid}, 32'h1);
        chk("stall_head_pc", bus.out_pc, 32'h8000_0000);
        chk("stall_issued", 32'(issued.size()), 32'd4);
        bus.out_ready = 1'b1;
        repeat (16) tick();
        chk("release_count_ok", {31'h0, obs.size() >= 8}, 32'h1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("release_pc%0d", i), obs[i].pc, 32'h8000_0000 + 32'(4 * i));
            chk($sformatf("release_instr%0d", i), obs[i].instr, instr_of(32'h8000_0000 + 32'(4 * i)));
        end

        // Request-ready toggling 1,0,0,1: address held while stalled, no PC skipped.
        do_reset();
        bus.out_ready = 1'b1;
        pat        = '{1'b1, 1'b0, 1'b0, 1'b1};
        prev_stall = 1'b0;
        prev_addr  = 32'h0;
        for (int c = 0; c < 16; c++) begin
            bus.imem_req_ready = pat[c % 4];
            #1;
            if (prev_stall) begin
                chk($sformatf("hold_valid_c%0d", c), {31'h0, bus.imem_req_valid}, 32'h1);
                chk($sformatf("hold_addr_c%0d", c), bus.imem_req_addr, prev_addr);
            end
            prev_stall = bus.imem_req_valid && !bus.imem_req_ready;
            prev_addr  = bus.imem_req_addr;
            tick();
        end
        chk("toggle_issued", 32'(issued.size()), 32'd8);
        for (int i = 0; i < issued.size(); i++) begin
            chk($sformatf("toggle_addr%0d", i), issued[i], 32'h8000_0000 + 32'(4 * i));
        end

        // Redirect with two requests outstanding and two entries queued.
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b0;
        repeat (3) tick();
        rsp_en = 1'b0;
        tick();
        #1;
        chk("pre_redir_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        chk("pre_redir_head", bus.out_pc, 32'h8000_0000);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        #1;
        chk("redir_cycle_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("post_redir_flushed", {31'h0, bus.out_valid}, 32'h0);
        rsp_en        = 1'b1;
        bus.out_ready = 1'b1;
        repeat (12) tick();
        chk("redir_obs_count_ok", {31'h0, obs.size() >= 3}, 32'h1);
        chk("redir_pc0", obs[0].pc, 32'h8000_0100);
        chk("redir_instr0", obs[0].instr, instr_of(32'h8000_0100));
        chk("redir_pc1", obs[1].pc, 32'h8000_0104);
        chk("redir_pc2", obs[2].pc, 32'h8000_0108);

        // Redirect coinciding with a response and an out handshake.
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        repeat (3) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        #1;
        chk("coinc_head", bus.out_pc, 32'h8000_0004);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("coinc_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        chk("coinc_req_addr", bus.imem_req_addr, 32'h8000_0200);
        chk("coinc_out_valid", {31'h0, bus.out_valid}, 32'h0);
        repeat (8) tick();
        chk("coinc_obs0", obs[0].pc, 32'h8000_0000);
        chk("coinc_obs1", obs[1].pc, 32'h8000_0004);
        chk("coinc_obs2", obs[2].pc, 32'h8000_0200);
        chk("coinc_obs3", obs[3].pc, 32'h8000_0204);
        chk("coinc_obs4", obs[4].pc, 32'h8000_0208);

        // PC wrap at the top of the address space.
        do_reset();
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        redirect_valid     = 1'b1;
        redirect_pc        = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_first_addr", bus.imem_req_addr, 32'hFFFF_FFFC);
        repeat (8) tick();
        chk("wrap_issued0", issued[0], 32'hFFFF_FFFC);
        chk("wrap_issued1", issued[1], 32'h0000_0000);
        chk("wrap_issued2", issued[2], 32'h0000_0004);
        chk("wrap_obs0", obs[0].pc, 32'hFFFF_FFFC);
        chk("wrap_obs1", obs[1].pc, 32'h0000_0000);
        chk("wrap_obs1_instr", obs[1].instr, instr_of(32'h0000_0000));

        // Reset in the middle of the stream.
        reset = 1'b1;
        #1;
        chk("midrst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        tick();
        reset = 1'b0;
        obs.delete();
        #1;
        chk("midrst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        chk("midrst_out_pc", bus.out_pc, 32'h0);
        chk("midrst_req_valid_after", {31'h0, bus.imem_req_valid}, 32'h1);
        chk("midrst_req_addr", bus.imem_req_addr, 32'h8000_0000);
        repeat (6) tick();
        chk("midrst_obs0", obs[0].pc, 32'h8000_0000);
        chk("midrst_obs1", obs[1].pc, 32'h8000_0004);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Parametrised instruction-fetch unit for the npc core.
- Generates sequential PCs from RESET_PC and issues them to instruction memory over a valid/ready request channel, accepting in-order responses.
- Buffers fetched {pc, instr} pairs in a DEPTH-entry queue and hands them to decode over a valid/ready channel.
- Supports redirect (branch/jump) with flush of the buffer and discard of in-flight responses.

Parameters:
- XLEN, 32, address/PC width
- ILEN, 32, instruction width
- DEPTH, 4, fetch-queue entries (power of 2, >=2)
- MAX_OUTSTANDING, 2, maximum issued-but-unanswered memory requests (>=1)
- RESET_PC, 32'h8000_0000, PC after reset

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- redirect_valid  in  1  redirect the fetch stream this cycle
- redirect_pc  in  XLEN  new fetch PC (low 2 bits ignored, forced 0)
- imem_req_valid  out  1  request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  request address
- imem_rsp_valid  in  1  response valid (always accepted, in order)
- imem_rsp_data  in  ILEN  response instruction
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_pc  out  XLEN  PC of head instruction
- out_instr  out  ILEN  head instruction

Behaviour:
- Reset (synchronous): fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0. Outputs: imem_req_valid=0 during the reset cycle, out_valid=0, out_pc=0, out_instr=0.
- Request issue:
  - imem_req_valid=1 when !reset && !redirect_valid && (outstanding + queue_count) < DEPTH && outstanding < MAX_OUTSTANDING. Buffer space is reserved per request, so a response can never overflow the queue.
  - imem_req_addr=fetch_pc.
  - On request handshake: fetch_pc += 4 (wraps modulo 2^XLEN); the PC is pushed onto an internal in-flight PC FIFO of depth MAX_OUTSTANDING; outstanding += 1.
  - Once asserted, valid and addr hold stable until ready, unless a redirect arrives; redirect may withdraw the request.
- Response:
  - On imem_rsp_valid: outstanding -= 1 and the head of the in-flight PC FIFO is popped.
  - If drop_cnt>0: drop_cnt -= 1 and the data is discarded.
  - Otherwise {popped pc, imem_rsp_data} is enqueued.
- Simultaneous events: a request handshake and a response in the same cycle leave outstanding unchanged. Push and pop in the same cycle are both legal, including on a full queue and with the same entry.
- Output:
  - out_valid = queue not empty; out_pc/out_instr = head entry, registered storage.
  - Head is popped when out_valid && out_ready.
  - Head is held stable while out_ready=0.
- Latency: request at cycle N with a same-cycle response yields out_valid at N+1 (registered queue). Minimum redirect-to-new-request latency is 1 cycle.
- Redirect (priority over all other updates except reset):
  - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}; queue flushed.
  - drop_cnt <= outstanding, net of any response arriving that cycle (that response is itself dropped); in-flight PC FIFO cleared consistently.
  - No request is issued in the redirect cycle.
  - Out handshake in the same cycle is still honoured; the consumer sees the entry consumed.
- Responses with imem_rsp_valid when outstanding=0 are a protocol error; assertion fires in simulation, state unchanged.
- Reset mid-operation discards everything. Responses arriving after reset to pre-reset requests are the memory's responsibility; the memory must also be reset.

Optional Feature:
- FETCH_TRACE_EN defined: on every out handshake, print "PC=0x%08x | instr=0x%08x" with out_pc, out_instr via $display. Also print "REDIRECT -> 0x%08x" on redirect.
- Undefined: no display statements; RTL otherwise identical.

Decomposition:
- Package ifu_pkg:
  - XLEN/ILEN defaults, RESET_PC default.
  - typedef fetch_entry_t {pc, instr}.
  - Constant INSTR_BYTES=4.
- Sub-module ifu_fifo:
  - Generic synchronous FIFO (WIDTH, DEPTH); push/pop/flush, count, full/empty.
  - Instantiated twice: fetch queue (fetch_entry_t) and in-flight PC FIFO (depth MAX_OUTSTANDING).

Test Plan:
- Reset then free-running memory with 1-cycle response and out_ready=1 -> out_pc sequence 0x80000000, 0x80000004, 0x80000008…; out_instr matches memory contents.
- out_ready=0 for 20 cycles -> exactly DEPTH=4 entries buffered, imem_req_valid drops to 0, head stays 0x80000000. Release -> no loss or duplication.
- imem_req_ready toggling 1,0,0,1 -> imem_req_addr stable while stalled; no PC skipped.
- Redirect to 0x80000103 with 2 requests outstanding -> both stale responses discarded, queue flushed. Next out_pc=0x80000100, then 0x80000104.
- Redirect in the same cycle as response and out handshake -> handshaken entry consumed, response dropped, no stale entry appears afterwards.
- fetch_pc=0xFFFFFFFC with XLEN=32 -> next request address 0x00000000 (wrap). Reset asserted mid-stream -> out_valid=0 next cycle, first request to 0x80000000.
